// File: rtl/ram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_pkg
// Purpose  : Shared widths, FSM encoding and grant IDs for the RAM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package ram_pkg;

  localparam int AW = 6;
  localparam int DW = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CMD  = 3'd1,
    WAIT = 3'd2,
    ACK  = 3'd3,
    CLR  = 3'd4
  } state_t;

  localparam logic GNT_A = 1'b0;
  localparam logic GNT_B = 1'b1;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Purpose  : Two-input round-robin picker (combinational). On a tie the
//            requester that was not granted last wins.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb2
  import ram_pkg::*;
(
  input  logic req_a,
  input  logic req_b,
  input  logic last,
  output logic gnt_valid,
  output logic gnt_id
);

  // Pick a single requester directly; on a tie, flip away from the last grant
  always_comb begin
    gnt_valid = req_a | req_b;
    gnt_id    = GNT_A;
    if (req_a && req_b) begin
      gnt_id = (last == GNT_A) ? GNT_B : GNT_A;
    end else if (req_b) begin
      gnt_id = GNT_B;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter
// Purpose  : Round-robin arbiter / sequencer sharing one 64x8 single-port
//            synchronous RAM between requesters A and B, with whole-memory
//            clear. Each transaction runs IDLE -> CMD -> WAIT -> ACK.
// Revision : 1.0 - initial release
// ============================================================================
module ram_arbiter #(
  parameter int AW = ram_pkg::AW,
  parameter int DW = ram_pkg::DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_ack,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_ack,
  output logic [DW-1:0] b_rdata,
  input  logic          clr_req,
  output logic          clr_done,
  output logic          ram_rst,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  import ram_pkg::*;

  state_t r_state;
  logic   r_last;   // requester granted most recently
  logic   r_who;    // requester owning the transaction in flight
  logic   r_we;     // latched direction of the transaction in flight
  logic   w_gnt_valid;
  logic   w_gnt_id;

  rr_arb2 u_rr_arb2 (
    .req_a     (a_req),
    .req_b     (b_req),
    .last      (r_last),
    .gnt_valid (w_gnt_valid),
    .gnt_id    (w_gnt_id)
  );

  // Sequencer: address and write data are latched straight into ram_addr /
  // ram_din on the IDLE->CMD edge and then held, so they double as the latched
  // request fields and keep the RAM read register stable through WAIT/ACK.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_last   <= GNT_B;
      r_who    <= GNT_A;
      r_we     <= 1'b0;
      a_ack    <= 1'b0;
      b_ack    <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
      clr_done <= 1'b0;
      ram_rst  <= 1'b0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
    end else begin
      a_ack    <= 1'b0;
      b_ack    <= 1'b0;
      clr_done <= 1'b0;
      ram_rst  <= 1'b0;
      ram_we   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (clr_req) begin
            ram_rst  <= 1'b1;
            clr_done <= 1'b1;
            r_state  <= CLR;
          end else if (w_gnt_valid) begin
            r_who    <= w_gnt_id;
            r_last   <= w_gnt_id;
            r_we     <= (w_gnt_id == GNT_B) ? b_we    : a_we;
            ram_we   <= (w_gnt_id == GNT_B) ? b_we    : a_we;
            ram_addr <= (w_gnt_id == GNT_B) ? b_addr  : a_addr;
            ram_din  <= (w_gnt_id == GNT_B) ? b_wdata : a_wdata;
            r_state  <= CMD;
          end
        end
        CMD: begin
          r_state <= WAIT;
        end
        WAIT: begin
          // RAM read register now holds the addressed word
          if (!r_we) begin
            if (r_who == GNT_B) b_rdata <= ram_dout;
            else                a_rdata <= ram_dout;
          end
          if (r_who == GNT_B) b_ack <= 1'b1;
          else                a_ack <= 1'b1;
          r_state <= ACK;
        end
        ACK: begin
          r_state <= IDLE;
        end
        CLR: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
